window_frame_sequencer: RTL

Frame-level controller in front of the `hamming_window` datapath. It accepts a sample stream with a valid/ready handshake and cuts it into frames of exactly FFT_SIZE samples. For each sample it drives the window stage with data, coefficient index and start/end-of-frame markers. It admits a new frame only when the downstream FFT signals readiness, and holds off input while the window pipeline drains.

---
 rtl/window_frame_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/window_frame_sequencer.sv
// Frame controller ahead of the hamming_window stage: cuts a valid/ready sample
// stream into FFT_SIZE-sample frames, gated by enable and downstream fft_ready.
module window_frame_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FFT_SIZE = 64,
  parameter int unsigned WIN_LAT  = 2,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IDX_W   = $clog2(FFT_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             fft_ready,
  output logic [WIDTH-1:0] win_data,
  output logic             win_valid,
  output logic [IDX_W-1:0] coef_idx,
  output logic             win_sof,
  output logic             win_eof,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count,
  output logic             busy
);

  localparam int unsigned     FL_W     = (WIN_LAT > 1) ? $clog2(WIN_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_SIZE - 1);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(WIN_LAT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FFT = 2'd1,
    STREAM   = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [FL_W-1:0]  flush_cnt, flush_n;
  logic             xfer;
  logic             last_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      flush_cnt <= flush_n;
    end
  end

  // s_ready is a pure state decode so s_valid never reaches it combinationally.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    flush_n    = flush_cnt;
    s_ready    = (state == STREAM);
    busy       = (state != IDLE);
    xfer       = s_valid && s_ready;
    last_flush = (state == FLUSH) && (flush_cnt == '0);
    frame_done = last_flush;

    unique case (state)
      IDLE: begin
        if (enable) state_n = WAIT_FFT;
      end
      WAIT_FFT: begin
        // A disabled block never starts a frame, even if the FFT is ready.
        if (!enable) begin
          state_n = IDLE;
        end else if (fft_ready) begin
          state_n = STREAM;
          idx_n   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          idx_n = idx + 1'b1;
          if (idx == LAST_IDX) begin
            state_n = FLUSH;
            flush_n = FL_LOAD;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          state_n = enable ? WAIT_FFT : IDLE;
        end else begin
          flush_n = flush_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      coef_idx  <= '0;
      win_sof   <= 1'b0;
      win_eof   <= 1'b0;
    end else begin
      win_valid <= xfer;
      if (xfer) begin
        win_data <= s_data;
        coef_idx <= idx;
        win_sof  <= (idx == '0);
        win_eof  <= (idx == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= '0;
    end else if (last_flush) begin
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule
